// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_EXEC  = 2'd1,
        REQ_TASK  = 2'd2
    } req_id_t;

    typedef enum logic {
        ARB_SHARED = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic req_id_t next_id(input req_id_t id);
        case (id)
            REQ_FETCH: next_id = REQ_EXEC;
            REQ_EXEC:  next_id = REQ_TASK;
            REQ_TASK:  next_id = REQ_FETCH;
            default:   next_id = REQ_FETCH;
        endcase
    endfunction

    function automatic req_id_t onehot_to_id(input logic [2:0] oh);
        case (oh)
            3'b010:  onehot_to_id = REQ_EXEC;
            3'b100:  onehot_to_id = REQ_TASK;
            default: onehot_to_id = REQ_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first requester at or after ptr in FETCH->EXEC->TASK order.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    // search order rotates with the pointer
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd0: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else             gnt = 3'b000;
            end
            2'd1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else             gnt = 3'b000;
            end
            2'd2: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else             gnt = 3'b000;
            end
            default: gnt = 3'b000;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a simple dual-port block RAM (A write, B read) between FETCH, EXEC and TASK.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              task_lock,
    output logic              task_owner,
    input  logic              f_rd_req,
    input  logic [ADDR_W-1:0] f_rd_addr,
    output logic              f_rd_gnt,
    output logic              f_rd_valid,
    output logic [DATA_W-1:0] f_rd_data,
    input  logic              e_rd_req,
    input  logic [ADDR_W-1:0] e_rd_addr,
    output logic              e_rd_gnt,
    output logic              e_rd_valid,
    output logic [DATA_W-1:0] e_rd_data,
    input  logic              t_rd_req,
    input  logic [ADDR_W-1:0] t_rd_addr,
    output logic              t_rd_gnt,
    output logic              t_rd_valid,
    output logic [DATA_W-1:0] t_rd_data,
    input  logic              e_wr_req,
    input  logic [ADDR_W-1:0] e_wr_addr,
    input  logic [DATA_W-1:0] e_wr_data,
    output logic              e_wr_gnt,
    input  logic              t_wr_req,
    input  logic [ADDR_W-1:0] t_wr_addr,
    input  logic [DATA_W-1:0] t_wr_data,
    output logic              t_wr_gnt,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dia,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dob
);

    arb_state_t state_r;
    req_id_t    ptr_r;
    req_id_t    ptr_next_s;
    logic [2:0] tag_r;
    logic       locked_s;
    logic       t_wr_win_s;
    logic       e_wr_win_s;
    logic       wr_any_s;
    logic [2:0] rd_req_s;
    logic [2:0] coll_s;
    logic [2:0] elig_s;
    logic [2:0] rr_gnt_s;
    logic [2:0] pre_gnt_s;
    logic [2:0] fx_gnt_s;
    logic [2:0] rd_gnt_s;

    assign locked_s = (state_r == ARB_LOCKED);

    // write port A: TASK beats EXEC, EXEC stalls while TASK owns the RAM
    always_comb begin
        t_wr_win_s = rst & t_wr_req;
        e_wr_win_s = rst & e_wr_req & ~t_wr_req & ~locked_s;
        wr_any_s   = t_wr_win_s | e_wr_win_s;
        ena        = wr_any_s;
        wea        = wr_any_s;
        if (t_wr_win_s) begin
            addra = t_wr_addr;
            dia   = t_wr_data;
        end else if (e_wr_win_s) begin
            addra = e_wr_addr;
            dia   = e_wr_data;
        end else begin
            addra = {ADDR_W{1'b0}};
            dia   = {DATA_W{1'b0}};
        end
    end

    // read candidates: lock mask, then drop any that hit this cycle's write address
    always_comb begin
        rd_req_s = {t_rd_req, e_rd_req & ~locked_s, f_rd_req & ~locked_s} & {3{rst}};
        coll_s   = {wr_any_s & (t_rd_addr == addra),
                    wr_any_s & (e_rd_addr == addra),
                    wr_any_s & (f_rd_addr == addra)};
        elig_s   = rd_req_s & ~coll_s;
    end

    rr_pick3 u_pick (
        .req (elig_s),
        .ptr (ptr_r),
        .gnt (rr_gnt_s)
    );

    // unmasked pick tells us who was first in line before collision deferral
    rr_pick3 u_pre (
        .req (rd_req_s),
        .ptr (ptr_r),
        .gnt (pre_gnt_s)
    );

    // final read grant, pointer update and port B drive
    always_comb begin
        if (elig_s[2])      fx_gnt_s = 3'b100;
        else if (elig_s[1]) fx_gnt_s = 3'b010;
        else if (elig_s[0]) fx_gnt_s = 3'b001;
        else                fx_gnt_s = 3'b000;

        rd_gnt_s = RR_EN ? rr_gnt_s : fx_gnt_s;

        if (rd_gnt_s == 3'b000)        ptr_next_s = ptr_r;
        else if (pre_gnt_s != rd_gnt_s) ptr_next_s = onehot_to_id(pre_gnt_s);
        else                            ptr_next_s = next_id(onehot_to_id(rd_gnt_s));

        enb = |rd_gnt_s;
        case (rd_gnt_s)
            3'b001:  addrb = f_rd_addr;
            3'b010:  addrb = e_rd_addr;
            3'b100:  addrb = t_rd_addr;
            default: addrb = {ADDR_W{1'b0}};
        endcase
    end

    // ownership FSM with registered task_owner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ARB_SHARED;
            task_owner <= 1'b0;
        end else begin
            case (state_r)
                ARB_SHARED: begin
                    if (task_lock && !e_wr_win_s) begin
                        state_r    <= ARB_LOCKED;
                        task_owner <= 1'b1;
                    end else begin
                        state_r    <= ARB_SHARED;
                        task_owner <= 1'b0;
                    end
                end
                ARB_LOCKED: begin
                    if (!task_lock) begin
                        state_r    <= ARB_SHARED;
                        task_owner <= 1'b0;
                    end else begin
                        state_r    <= ARB_LOCKED;
                        task_owner <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ARB_SHARED;
                    task_owner <= 1'b0;
                end
            endcase
        end
    end

    // read owner tag and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r <= 3'b000;
            ptr_r <= REQ_FETCH;
        end else begin
            tag_r <= rd_gnt_s;
            ptr_r <= ptr_next_s;
        end
    end

    assign f_rd_gnt   = rd_gnt_s[0];
    assign e_rd_gnt   = rd_gnt_s[1];
    assign t_rd_gnt   = rd_gnt_s[2];
    assign f_rd_valid = tag_r[0];
    assign e_rd_valid = tag_r[1];
    assign t_rd_valid = tag_r[2];
    assign f_rd_data  = dob;
    assign e_rd_data  = dob;
    assign t_rd_data  = dob;
    assign e_wr_gnt   = e_wr_win_s;
    assign t_wr_gnt   = t_wr_win_s;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a behavioural model.
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, task_lock;
    logic          f_rd_req, e_rd_req, t_rd_req, e_wr_req, t_wr_req;
    logic [AW-1:0] f_rd_addr, e_rd_addr, t_rd_addr, e_wr_addr, t_wr_addr;
    logic [DW-1:0] e_wr_data, t_wr_data;

    logic          task_owner, f_rd_gnt, e_rd_gnt, t_rd_gnt, f_rd_valid, e_rd_valid, t_rd_valid;
    logic [DW-1:0] f_rd_data, e_rd_data, t_rd_data, dia, dob;
    logic          e_wr_gnt, t_wr_gnt, ena, wea, enb;
    logic [AW-1:0] addra, addrb;

    logic          fx_task_owner, fx_f_rd_gnt, fx_e_rd_gnt, fx_t_rd_gnt;
    logic          fx_f_rd_valid, fx_e_rd_valid, fx_t_rd_valid;
    logic [DW-1:0] fx_f_rd_data, fx_e_rd_data, fx_t_rd_data, fx_dia;
    logic          fx_e_wr_gnt, fx_t_wr_gnt, fx_ena, fx_wea, fx_enb;
    logic [AW-1:0] fx_addra, fx_addrb;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .task_lock(task_lock), .task_owner(task_owner),
        .f_rd_req(f_rd_req), .f_rd_addr(f_rd_addr), .f_rd_gnt(f_rd_gnt), .f_rd_valid(f_rd_valid), .f_rd_data(f_rd_data),
        .e_rd_req(e_rd_req), .e_rd_addr(e_rd_addr), .e_rd_gnt(e_rd_gnt), .e_rd_valid(e_rd_valid), .e_rd_data(e_rd_data),
        .t_rd_req(t_rd_req), .t_rd_addr(t_rd_addr), .t_rd_gnt(t_rd_gnt), .t_rd_valid(t_rd_valid), .t_rd_data(t_rd_data),
        .e_wr_req(e_wr_req), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data), .e_wr_gnt(e_wr_gnt),
        .t_wr_req(t_wr_req), .t_wr_addr(t_wr_addr), .t_wr_data(t_wr_data), .t_wr_gnt(t_wr_gnt),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_fix (
        .clk(clk), .rst(rst), .task_lock(task_lock), .task_owner(fx_task_owner),
        .f_rd_req(f_rd_req), .f_rd_addr(f_rd_addr), .f_rd_gnt(fx_f_rd_gnt), .f_rd_valid(fx_f_rd_valid), .f_rd_data(fx_f_rd_data),
        .e_rd_req(e_rd_req), .e_rd_addr(e_rd_addr), .e_rd_gnt(fx_e_rd_gnt), .e_rd_valid(fx_e_rd_valid), .e_rd_data(fx_e_rd_data),
        .t_rd_req(t_rd_req), .t_rd_addr(t_rd_addr), .t_rd_gnt(fx_t_rd_gnt), .t_rd_valid(fx_t_rd_valid), .t_rd_data(fx_t_rd_data),
        .e_wr_req(e_wr_req), .e_wr_addr(e_wr_addr), .e_wr_data(e_wr_data), .e_wr_gnt(fx_e_wr_gnt),
        .t_wr_req(t_wr_req), .t_wr_addr(t_wr_addr), .t_wr_data(t_wr_data), .t_wr_gnt(fx_t_wr_gnt),
        .ena(fx_ena), .wea(fx_wea), .addra(fx_addra), .dia(fx_dia), .enb(fx_enb), .addrb(fx_addrb), .dob(dob)
    );

    // RAM stand-in: port A write, port B registered read
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (ena && wea) ram[addra] <= dia;
        if (enb) dob <= ram[addrb];
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [DW-1:0] mem_m [0:1023];
    int            m_ptr;
    bit            m_locked;
    bit [2:0]      m_pend;
    logic [DW-1:0] m_pdata;

    // expectations for the current cycle
    bit            ex_wt, ex_we, ex_rd;
    logic [AW-1:0] ex_wa, ex_ra;
    logic [DW-1:0] ex_wd;
    bit [2:0]      ex_gr, ex_gf;
    int            ex_win, ex_winf, ex_first;

    task automatic eval();
        logic [AW-1:0] ra [3];
        bit [2:0]      rq;
        bit            ok;
        int            i;
        #1;
        if (!rst) begin
            m_ptr    = 0;
            m_locked = 1'b0;
            m_pend   = 3'b000;
        end
        ra[0] = f_rd_addr;
        ra[1] = e_rd_addr;
        ra[2] = t_rd_addr;
        rq    = {t_rd_req, e_rd_req, f_rd_req};
        ex_wt = rst && t_wr_req;
        ex_we = rst && e_wr_req && !t_wr_req && !m_locked;
        ex_wa = ex_wt ? t_wr_addr : (ex_we ? e_wr_addr : 10'd0);
        ex_wd = ex_wt ? t_wr_data : (ex_we ? e_wr_data : 8'd0);
        ex_first = -1;
        ex_win   = -1;
        ex_winf  = -1;
        for (int k = 0; k < 3; k++) begin
            i = (m_ptr + k) % 3;
            if (rst && rq[i] && (i == 2 || !m_locked)) begin
                if (ex_first < 0) ex_first = i;
                ok = !((ex_wt || ex_we) && ra[i] == ex_wa);
                if (ok && ex_win < 0) ex_win = i;
            end
        end
        for (int k = 2; k >= 0; k--) begin
            if (rst && rq[k] && (k == 2 || !m_locked) && !((ex_wt || ex_we) && ra[k] == ex_wa)
                && ex_winf < 0) ex_winf = k;
        end
        ex_rd = (ex_win >= 0);
        ex_gr = ex_rd ? 3'(1 << ex_win) : 3'b000;
        ex_gf = (ex_winf >= 0) ? 3'(1 << ex_winf) : 3'b000;
        ex_ra = ex_rd ? ra[ex_win] : 10'd0;

        check_value("rd_gnt", 32'({t_rd_gnt, e_rd_gnt, f_rd_gnt}), 32'(ex_gr));
        check_value("wr_gnt", 32'({t_wr_gnt, e_wr_gnt}), 32'({ex_wt, ex_we}));
        check_value("port_a", 32'({ena, wea, addra, dia}), 32'({ex_wt | ex_we, ex_wt | ex_we, ex_wa, ex_wd}));
        check_value("port_b", 32'({enb, addrb}), 32'({ex_rd, ex_ra}));
        check_value("fix_gnt", 32'({fx_t_rd_gnt, fx_e_rd_gnt, fx_f_rd_gnt}), 32'(ex_gf));
        check_value("rd_valid", 32'({t_rd_valid, e_rd_valid, f_rd_valid}), 32'(m_pend));
        if (m_pend != 3'b000)
            check_value("rd_data", 32'(m_pend[0] ? f_rd_data : (m_pend[1] ? e_rd_data : t_rd_data)), 32'(m_pdata));
        check_value("owner", 32'(task_owner), 32'(m_locked));
        check_value("fix_owner", 32'(fx_task_owner), 32'(m_locked));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (ex_rd) m_pdata = mem_m[ex_ra];
            if (ex_wt || ex_we) mem_m[ex_wa] = ex_wd;
            m_pend = ex_gr;
            if (ex_rd) m_ptr = (ex_first != ex_win) ? ex_first : (ex_win + 1) % 3;
            if (!m_locked && task_lock && !ex_we) m_locked = 1'b1;
            else if (m_locked && !task_lock) m_locked = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        f_rd_req = 1'b0; e_rd_req = 1'b0; t_rd_req = 1'b0;
        e_wr_req = 1'b0; t_wr_req = 1'b0;
    endtask

    bit [2:0] seen, prev, cur;

    initial begin
        for (int a = 0; a < 1024; a++) begin
            ram[a]   = init_val(a);
            mem_m[a] = init_val(a);
        end
        rst = 1'b0; task_lock = 1'b0;
        f_rd_addr = 10'd0; e_rd_addr = 10'd0; t_rd_addr = 10'd0;
        e_wr_addr = 10'd0; t_wr_addr = 10'd0; e_wr_data = 8'd0; t_wr_data = 8'd0;
        f_rd_req = 1'b1; e_rd_req = 1'b1; t_rd_req = 1'b1; e_wr_req = 1'b1; t_wr_req = 1'b1;
        @(negedge clk);

        // requests are ignored while in reset
        eval();
        check_value("rst_enables", 32'({ena, wea, enb, f_rd_gnt, t_wr_gnt}), 32'd0);
        tick();
        rst = 1'b1;
        idle();

        // single fetch read
        f_rd_req = 1'b1; f_rd_addr = 10'h050;
        eval();
        check_value("single_gnt", 32'(f_rd_gnt), 32'd1);
        tick();
        f_rd_req = 1'b0;
        eval();
        check_value("single_valid", 32'(f_rd_valid), 32'd1);
        check_value("single_data", 32'(f_rd_data), 32'(init_val(10'h050)));
        tick();

        // everyone reads every cycle: rotation and fixed-priority winner
        f_rd_req = 1'b1; e_rd_req = 1'b1; t_rd_req = 1'b1;
        f_rd_addr = 10'h100; e_rd_addr = 10'h101; t_rd_addr = 10'h102;
        seen = 3'b000; prev = 3'b000;
        for (int c = 0; c < 6; c++) begin
            eval();
            cur = {t_rd_gnt, e_rd_gnt, f_rd_gnt};
            check_value("fix_task_wins", 32'({fx_t_rd_gnt, fx_e_rd_gnt, fx_f_rd_gnt}), 32'd4);
            if (c > 0) check_value("rr_order", 32'(cur), 32'({prev[1:0], prev[2]}));
            seen = seen | cur;
            if (c == 2 || c == 5) begin
                check_value("rr_cover", 32'(seen), 32'd7);
                seen = 3'b000;
            end
            prev = cur;
            tick();
        end
        idle();

        // simultaneous writes: TASK first, EXEC next
        e_wr_req = 1'b1; e_wr_addr = 10'h010; e_wr_data = 8'hAA;
        t_wr_req = 1'b1; t_wr_addr = 10'h011; t_wr_data = 8'h55;
        eval();
        check_value("wr_task_first", 32'({t_wr_gnt, e_wr_gnt}), 32'd2);
        tick();
        t_wr_req = 1'b0;
        eval();
        check_value("wr_exec_next", 32'({t_wr_gnt, e_wr_gnt}), 32'd1);
        tick();
        e_wr_req = 1'b0; f_rd_req = 1'b1; f_rd_addr = 10'h010;
        eval(); tick();
        f_rd_addr = 10'h011;
        eval();
        check_value("wr_read_aa", 32'(f_rd_data), 32'h0AA);
        tick();
        f_rd_req = 1'b0;
        eval();
        check_value("wr_read_55", 32'(f_rd_data), 32'h055);
        tick();

        // read/write collision defers the read by one cycle
        e_wr_req = 1'b1; e_wr_addr = 10'h020; e_wr_data = 8'h33;
        f_rd_req = 1'b1; f_rd_addr = 10'h020;
        eval();
        check_value("coll_defer", 32'(f_rd_gnt), 32'd0);
        tick();
        e_wr_req = 1'b0;
        eval();
        check_value("coll_grant", 32'(f_rd_gnt), 32'd1);
        tick();
        f_rd_req = 1'b0;
        eval();
        check_value("coll_data", 32'(f_rd_data), 32'h033);
        tick();

        // exclusive ownership for the task switcher
        f_rd_req = 1'b1; e_rd_req = 1'b1; t_rd_req = 1'b1; task_lock = 1'b1;
        eval(); tick();
        eval();
        check_value("lock_owner", 32'(task_owner), 32'd1);
        check_value("lock_stall", 32'({e_rd_gnt, f_rd_gnt}), 32'd0);
        check_value("lock_task", 32'(t_rd_gnt), 32'd1);
        tick();
        task_lock = 1'b0;
        eval(); tick();
        eval();
        check_value("unlock_owner", 32'(task_owner), 32'd0);
        check_value("unlock_serve", 32'(f_rd_gnt | e_rd_gnt), 32'd1);
        tick();
        idle();

        // reset the cycle after a grant drops the pending read
        f_rd_req = 1'b1; f_rd_addr = 10'h055;
        eval(); tick();
        f_rd_req = 1'b0; e_wr_req = 1'b1; rst = 1'b0;
        eval();
        check_value("rst_valid", 32'({t_rd_valid, e_rd_valid, f_rd_valid}), 32'd0);
        check_value("rst_ram_en", 32'({ena, wea, enb}), 32'd0);
        tick();
        rst = 1'b1; e_wr_req = 1'b0;
        f_rd_req = 1'b1; e_rd_req = 1'b1; t_rd_req = 1'b1;
        eval();
        check_value("rst_first_fetch", 32'(f_rd_gnt), 32'd1);
        tick();
        idle();

        // randomized traffic on a narrow address window to force collisions
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 99) != 0);
            f_rd_req  = ($urandom_range(0, 3) != 0);
            e_rd_req  = ($urandom_range(0, 3) != 0);
            t_rd_req  = ($urandom_range(0, 3) != 0);
            e_wr_req  = ($urandom_range(0, 2) == 0);
            t_wr_req  = ($urandom_range(0, 3) == 0);
            f_rd_addr = 10'($urandom_range(0, 7));
            e_rd_addr = 10'($urandom_range(0, 7));
            t_rd_addr = 10'($urandom_range(0, 7));
            e_wr_addr = 10'($urandom_range(0, 7));
            t_wr_addr = 10'($urandom_range(0, 7));
            e_wr_data = 8'($urandom);
            t_wr_data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) task_lock = ~task_lock;
            eval();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
